// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared constants for the Ethernet receive path.
//   - Upstream FSM state encoding (must match Ethernet_RX_frame_5cd).
//   - CRC-32 constants (reflected, LSB-first).
//   - crc32_d8(): fold one byte into a running CRC register.
//   - chk_state_t: frame-checker FSM states.
package eth_rx_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {CHK_IDLE, CHK_FRAME} chk_state_t;

  // Bit-serial reflected CRC, byte LSB first; unrolls to a pure XOR network.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_stats.sv
// eth_rx_stats: good/bad frame counters, built only when ETH_RX_STATS_EN
// is defined.
// Ports:
//   clk, rst        - receive clock, async active-high reset
//   frame_done      - one-cycle verdict strobe
//   frame_ok        - verdict, qualified by frame_done
//   cnt_good        - 32-bit wrapping count of good frames
//   cnt_bad         - 32-bit wrapping count of bad frames
`ifdef ETH_RX_STATS_EN
module eth_rx_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_done,
  input  logic        frame_ok,
  output logic [31:0] cnt_good,
  output logic [31:0] cnt_bad
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else if (frame_done) begin
      if (frame_ok) cnt_good <= cnt_good + 32'd1;
      else          cnt_bad  <= cnt_bad + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: frame check stage after Ethernet_RX_frame_5cd.
// Runs CRC-32 over DA..FCS, counts bytes, tracks rx_er, and issues a
// one-cycle verdict when the frame ends.
// Optional build macro: ETH_RX_STATS_EN adds good/bad frame counters;
// without it o_cnt_good/o_cnt_bad are tied to 0.
// Ports:
//   i_rx_clk, i_rst     - receive clock, async active-high reset
//   i_fsm_state         - upstream FSM state (eth_rx_pkg encoding)
//   i_rx_dv_4cd/er/d4cd - delayed GMII valid, error, data
//   o_frame_done        - one-cycle end-of-frame strobe
//   o_frame_ok          - frame good (with o_frame_done)
//   o_crc_err/len_err/rx_err - individual verdict flags
//   o_frame_len         - byte count, saturating at 0xFFFF
//   o_cnt_good/o_cnt_bad- statistics counters
module eth_rx_fcs_check
  import eth_rx_pkg::*;
#(
  parameter int unsigned pMIN_LEN = 64,
  parameter int unsigned pMAX_LEN = 1518
) (
  input  logic        i_rx_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_fsm_state,
  input  logic        i_rx_dv_4cd,
  input  logic        i_rx_er_4cd,
  input  logic [7:0]  i_rx_d4cd,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic        o_rx_err,
  output logic [15:0] o_frame_len,
  output logic [31:0] o_cnt_good,
  output logic [31:0] o_cnt_bad
);

  chk_state_t  state, state_nxt;
  logic        q, start, fin;
  logic [31:0] crc;
  logic [15:0] len;
  logic        rx_err;
  logic        crc_bad, len_bad;

  // State leaving ST_DATA with dv still high ends the frame like dv falling.
  assign q = i_rx_dv_4cd && (i_fsm_state == ST_DATA);

  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) state <= CHK_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fin       = 1'b0;
    case (state)
      CHK_IDLE:  if (q)  begin state_nxt = CHK_FRAME; start = 1'b1; end
      CHK_FRAME: if (!q) begin state_nxt = CHK_IDLE;  fin   = 1'b1; end
      default:   state_nxt = CHK_IDLE;
    endcase
  end

  assign crc_bad = (crc != CRC32_RESIDUE);
  assign len_bad = (32'(len) < pMIN_LEN) || (32'(len) > pMAX_LEN);

  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      crc          <= CRC32_INIT;
      len          <= '0;
      rx_err       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_crc_err    <= 1'b0;
      o_len_err    <= 1'b0;
      o_rx_err     <= 1'b0;
      o_frame_len  <= '0;
    end else begin
      o_frame_done <= fin;
      // First byte folds straight into the preset, so the accumulators
      // never need a separate clear cycle between back-to-back frames.
      if (start) begin
        crc    <= crc32_d8(CRC32_INIT, i_rx_d4cd);
        len    <= 16'd1;
        rx_err <= i_rx_er_4cd;
      end else if (q) begin
        crc    <= crc32_d8(crc, i_rx_d4cd);
        len    <= (len == 16'hFFFF) ? len : len + 16'd1;
        rx_err <= rx_err | i_rx_er_4cd;
      end
      if (fin) begin
        o_crc_err   <= crc_bad;
        o_len_err   <= len_bad;
        o_rx_err    <= rx_err;
        o_frame_ok  <= !(crc_bad || len_bad || rx_err);
        o_frame_len <= len;
      end
    end
  end

`ifdef ETH_RX_STATS_EN
  eth_rx_stats u_stats (
    .clk        (i_rx_clk),
    .rst        (i_rst),
    .frame_done (o_frame_done),
    .frame_ok   (o_frame_ok),
    .cnt_good   (o_cnt_good),
    .cnt_bad    (o_cnt_bad)
  );
`else
  assign o_cnt_good = '0;
  assign o_cnt_bad  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check: the stimulus process pushes the
// expected verdict (including the strobe cycle) for each frame; a negedge
// monitor pops and compares whenever o_frame_done is seen.
module tb_eth_rx_fcs_check;
  import eth_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st  = ST_IDLE;
  logic        dv  = 1'b0;
  logic        er  = 1'b0;
  logic [7:0]  d   = 8'h00;
  logic        frame_done, frame_ok, crc_err, len_err, rx_err;
  logic [15:0] frame_len;
  logic [31:0] cnt_good, cnt_bad;

  eth_rx_fcs_check #(.pMIN_LEN(64), .pMAX_LEN(1518)) dut (
    .i_rx_clk     (clk),
    .i_rst        (rst),
    .i_fsm_state  (st),
    .i_rx_dv_4cd  (dv),
    .i_rx_er_4cd  (er),
    .i_rx_d4cd    (d),
    .o_frame_done (frame_done),
    .o_frame_ok   (frame_ok),
    .o_crc_err    (crc_err),
    .o_len_err    (len_err),
    .o_rx_err     (rx_err),
    .o_frame_len  (frame_len),
    .o_cnt_good   (cnt_good),
    .o_cnt_bad    (cnt_bad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ok, crc_e, len_e, rx_e;
    logic [15:0] len;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fr[$];
  int          n_tests = 0, n_fail = 0;
  int          exp_good = 0, exp_bad = 0;

  // Reflected CRC-32 nibble table (poly 0xEDB88320).
  logic [31:0] ntab [16] = '{
    32'h00000000, 32'h1DB71064, 32'h3B6E20C8, 32'h26D930AC,
    32'h76DC4190, 32'h6B6B51F4, 32'h4DB26158, 32'h5005713C,
    32'hEDB88320, 32'hF00F9344, 32'hD6D6A3E8, 32'hCB61B38C,
    32'h9B64C2B0, 32'h86D3D2D4, 32'hA00AE278, 32'hBDBDF21C};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Standard Ethernet CRC-32 (with final complement) over fr[0..n-1].
  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fr[i]};
      c = (c >> 4) ^ ntab[c[3:0]];
      c = (c >> 4) ^ ntab[c[3:0]];
    end
    return ~c;
  endfunction

  task automatic build_zero(input int n);
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(8'h00);
    f = ref_fcs(n);
    fr.push_back(f[7:0]);  fr.push_back(f[15:8]);
    fr.push_back(f[23:16]); fr.push_back(f[31:24]);
  endtask

  task automatic push_exp(input logic crc_e, input logic rx_e, input int at);
    exp_t e;
    e.len   = 16'(fr.size());
    e.crc_e = crc_e;
    e.rx_e  = rx_e;
    e.len_e = (fr.size() < 64) || (fr.size() > 1518);
    e.ok    = !(e.crc_e || e.len_e || e.rx_e);
    e.at    = at;
    if (e.ok) exp_good++; else exp_bad++;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] s, input logic v, input logic e, input logic [7:0] b);
    @(posedge clk); #1;
    st = s; dv = v; er = e; d = b;
  endtask

  // pre: send preamble/SFD first; er_idx/rst_idx: byte index or -1;
  // end_st: end the frame by leaving ST_DATA with dv still high.
  task automatic send(input bit pre, input int er_idx, input int rst_idx,
                      input bit end_st, input bit crc_e, input int gap);
    bit aborted;
    aborted = 1'b0;
    if (pre) begin
      repeat (7) drive(ST_PREAMBLE, 1'b1, 1'b0, 8'h55);
      drive(ST_SFD, 1'b1, 1'b0, 8'hD5);
    end
    for (int i = 0; i < fr.size() && !aborted; i++) begin
      drive(ST_DATA, 1'b1, (i == er_idx), fr[i]);
      if (i == rst_idx) begin
        rst = 1'b1;
        drive(ST_IDLE, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      push_exp(crc_e, (er_idx >= 0), cyc + 2);
      drive(ST_IDLE, end_st, 1'b0, 8'h00);
    end
    repeat (gap) drive(ST_IDLE, 1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: strobe at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc),      32'(e.at));
        chk("frame_ok",   32'(frame_ok), 32'(e.ok));
        chk("crc_err",    32'(crc_err),  32'(e.crc_e));
        chk("len_err",    32'(len_err),  32'(e.len_e));
        chk("rx_err",     32'(rx_err),   32'(e.rx_e));
        chk("frame_len",  32'(frame_len), 32'(e.len));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
    chk({tag, "_ok"},    32'(frame_ok),   32'd0);
    chk({tag, "_crc"},   32'(crc_err),    32'd0);
    chk({tag, "_len"},   32'(len_err),    32'd0);
    chk({tag, "_rx"},    32'(rx_err),     32'd0);
    chk({tag, "_flen"},  32'(frame_len),  32'd0);
    chk({tag, "_cgood"}, cnt_good,        32'd0);
    chk({tag, "_cbad"},  cnt_bad,         32'd0);
  endtask

  task automatic chk_stats(input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef ETH_RX_STATS_EN
    chk({tag, "_cnt_good"}, cnt_good, 32'(exp_good));
    chk({tag, "_cnt_bad"},  cnt_bad,  32'(exp_bad));
`else
    chk({tag, "_cnt_good"}, cnt_good, 32'd0);
    chk({tag, "_cnt_bad"},  cnt_bad,  32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 60 zero bytes + FCS: good 64-byte frame.
    build_zero(60);
    send(1'b1, -1, -1, 1'b0, 1'b0, 3);

    // "123456789" + known FCS: CRC ok, too short.
    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    send(1'b1, -1, -1, 1'b0, 1'b0, 3);

    // Single-bit corruption at byte 20.
    build_zero(60);
    fr[20] = fr[20] ^ 8'h01;
    send(1'b1, -1, -1, 1'b0, 1'b1, 3);

    // 1519-byte frame, one-cycle gap, then a good frame with fresh CRC.
    build_zero(1515);
    send(1'b1, -1, -1, 1'b0, 1'b0, 0);
    build_zero(60);
    send(1'b0, -1, -1, 1'b0, 1'b0, 3);

    // rx_er on byte 30.
    build_zero(60);
    send(1'b1, 30, -1, 1'b0, 1'b0, 3);

    // Good frame terminated by FSM leaving ST_DATA with dv still high.
    build_zero(60);
    send(1'b1, -1, -1, 1'b1, 1'b0, 3);

    drain();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("verdict_hold_len", 32'(frame_len), 32'd64);
    chk("verdict_hold_ok",  32'(frame_ok),  32'd1);
    chk_stats("stats");

    // Reset at byte 40: no strobe, everything cleared.
    build_zero(60);
    send(1'b1, -1, 40, 1'b0, 1'b0, 3);
    exp_good = 0; exp_bad = 0;
    @(negedge clk);
    chk_idle_outputs("midrst");

    // Fresh frame after the reset is judged cleanly.
    build_zero(60);
    send(1'b1, -1, -1, 1'b0, 1'b0, 3);
    drain();
    chk_stats("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
